// File: rtl/score_display_ctrl.sv
// Binary score to per-digit BCD + blank flags for a seven-segment bank.
// Double-dabble conversion over WIDTH cycles; outputs update atomically on completion.
module score_display_ctrl #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                clock,
  input  logic                reset_L,
  input  logic [WIDTH-1:0]    value_in,
  input  logic                load,
  input  logic                lz_blank_en,
  input  logic                display_en,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic [DIGITS-1:0]   blank_out
);

  localparam int BW   = 4 * DIGITS;
  localparam int CW   = (WIDTH > BW) ? WIDTH : BW;
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]     LIMIT     = CW'(10 ** DIGITS);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1'b1);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [BW-1:0]       acc_q, acc_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [DIGITS-1:0]   blank_q, blank_d;

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // A digit goes dark only if it and every more significant digit are zero.
  function automatic logic [DIGITS-1:0] blank_calc(input logic [BW-1:0] b,
                                                   input logic en, input logic lz);
    logic [DIGITS-1:0] r;
    logic              seen;
    r    = '0;
    seen = 1'b0;
    if (!en) begin
      r = '1;
    end else if (lz) begin
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (b[4*i +: 4] != 4'd0) seen = 1'b1;
        r[i] = ~seen;
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    blank_d = blank_q;
    case (state_q)
      IDLE: begin
        blank_d = blank_calc(bcd_q, display_en, lz_blank_en);
        if (load) begin
          bin_d   = (CW'(value_in) >= LIMIT) ? WIDTH'(LIMIT - CW'(1)) : value_in;
          acc_d   = '0;
          cnt_d   = CNTW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {acc_d, bin_d} = {add3(acc_q), bin_q} << 1;
        cnt_d          = cnt_q - 1'b1;
        if (cnt_q == CNTW'(1)) state_d = UPDATE;
      end
      UPDATE: begin
        bcd_d   = acc_q;
        blank_d = blank_calc(acc_q, display_en, lz_blank_en);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      blank_q <= BLANK_RST;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
    end
  end

  // Conversion working registers are always reloaded on capture, so no reset.
  always_ff @(posedge clock) begin
    bin_q <= bin_d;
    acc_q <= acc_d;
    cnt_q <= cnt_d;
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign bcd_out   = bcd_q;
  assign blank_out = blank_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench for score_display_ctrl (WIDTH=14, DIGITS=4) against a
// decimal-arithmetic reference model.
module tb_score_display_ctrl;

  logic        clock = 1'b0;
  logic        reset_L;
  logic [13:0] value_in;
  logic        load;
  logic        lz_blank_en;
  logic        display_en;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic [3:0]  blank_out;

  int checks   = 0;
  int failures = 0;

  score_display_ctrl #(.WIDTH(14), .DIGITS(4)) dut (
    .clock(clock), .reset_L(reset_L), .value_in(value_in), .load(load),
    .lz_blank_en(lz_blank_en), .display_en(display_en), .busy(busy),
    .done(done), .bcd_out(bcd_out), .blank_out(blank_out)
  );

  always #5 clock = ~clock;

  function automatic int sat(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic logic [15:0] exp_bcd(input int v);
    logic [15:0] r;
    int s, d;
    s = sat(v);
    d = 1;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((s / d) % 10);
      d = d * 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_blank(input int v, input bit lz, input bit de);
    logic [3:0] r;
    int s, nd;
    s  = sat(v);
    nd = (s >= 1000) ? 4 : (s >= 100) ? 3 : (s >= 10) ? 2 : 1;
    for (int i = 0; i < 4; i++) r[i] = !de ? 1'b1 : (lz && i >= nd);
    return r;
  endfunction

  // Advance one cycle at a time (sampling #1 after each edge) until done or budget.
  task automatic wait_done(input int start, output int at);
    at = 0;
    for (int c = start; c <= 40 && at == 0; c++) begin
      if (done) at = c;
      else begin
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic run_conv(input int v, input bit lz, input bit de, input string nm);
    logic [15:0] pbcd;
    logic [3:0]  pbl;
    int busy_n, done_at;
    @(negedge clock); lz_blank_en = lz; display_en = de;
    @(negedge clock); value_in = 14'(v); load = 1'b1;
    pbcd = bcd_out; pbl = blank_out;
    @(posedge clock); #1 load = 1'b0;
    busy_n = 0; done_at = 0;
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      if (done) done_at = c;
      else begin
        if (busy) busy_n++;
        checks++;
        if (bcd_out !== pbcd || blank_out !== pbl) begin
          failures++;
          $display("FAIL %s_hold cyc=%0d got bcd=%h blank=%b want bcd=%h blank=%b",
                   nm, c, bcd_out, blank_out, pbcd, pbl);
        end
        @(posedge clock); #1;
      end
    end
    checks++;
    if (done_at !== 16) begin
      failures++;
      $display("FAIL %s_latency got done at cycle %0d want 16", nm, done_at);
    end
    checks++;
    if (busy_n !== 15) begin
      failures++;
      $display("FAIL %s_busy_cycles got %0d want 15", nm, busy_n);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_at_done got %b want 0", nm, busy);
    end
    checks++;
    if (bcd_out !== exp_bcd(v)) begin
      failures++;
      $display("FAIL %s_bcd got %h want %h", nm, bcd_out, exp_bcd(v));
    end
    checks++;
    if (blank_out !== exp_blank(v, lz, de)) begin
      failures++;
      $display("FAIL %s_blank got %b want %b", nm, blank_out, exp_blank(v, lz, de));
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if (bcd_out !== 16'h0000 || blank_out !== 4'b1110 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL reset_state got bcd=%h blank=%b busy=%b done=%b want 0000 1110 0 0",
                 bcd_out, blank_out, busy, done);
      end
    end
  endtask

  task automatic test_basic();
    run_conv(1234, 1, 1, "conv1234");
    run_conv(7, 1, 1, "conv7_lz");
    run_conv(0, 1, 1, "conv0_lz");
    run_conv(7, 0, 1, "conv7_nolz");
  endtask

  task automatic test_saturation();
    run_conv(12000, 1, 1, "sat12000");
    run_conv(10000, 1, 1, "sat10000");
    run_conv(16383, 0, 1, "sat16383");
    run_conv(9999, 1, 1, "max9999");
  endtask

  task automatic test_load_while_busy();
    int at;
    @(negedge clock); lz_blank_en = 1'b1; display_en = 1'b1;
    @(negedge clock); value_in = 14'd4321; load = 1'b1;
    @(posedge clock); #1 load = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    value_in = 14'd55; load = 1'b1;
    @(posedge clock); #1 load = 1'b0;
    wait_done(6, at);
    checks++;
    if (at !== 16) begin
      failures++;
      $display("FAIL busy_load_latency got %0d want 16", at);
    end
    checks++;
    if (bcd_out !== 16'h4321) begin
      failures++;
      $display("FAIL busy_load_ignored got %h want 4321", bcd_out);
    end
    // Load in the done cycle must be accepted.
    value_in = 14'd55; load = 1'b1;
    @(posedge clock); #1 load = 1'b0;
    wait_done(1, at);
    checks++;
    if (at !== 16) begin
      failures++;
      $display("FAIL done_cycle_load_latency got %0d want 16", at);
    end
    checks++;
    if (bcd_out !== exp_bcd(55) || blank_out !== exp_blank(55, 1, 1)) begin
      failures++;
      $display("FAIL done_cycle_load got %h/%b want %h/%b",
               bcd_out, blank_out, exp_bcd(55), exp_blank(55, 1, 1));
    end
  endtask

  task automatic test_display_toggle();
    logic [15:0] held;
    held = bcd_out;
    @(negedge clock); display_en = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (blank_out !== 4'b1111 || bcd_out !== held || done !== 1'b0) begin
      failures++;
      $display("FAIL display_off got blank=%b bcd=%h done=%b want 1111 %h 0",
               blank_out, bcd_out, done, held);
    end
    @(negedge clock); display_en = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (blank_out !== exp_blank(int'(held[15:12]) * 1000 + int'(held[11:8]) * 100 +
                                int'(held[7:4]) * 10 + int'(held[3:0]), 1, 1)) begin
      failures++;
      $display("FAIL display_on got blank=%b", blank_out);
    end
  endtask

  task automatic test_reset_mid_conv();
    bit saw_done;
    @(negedge clock); lz_blank_en = 1'b1; display_en = 1'b1;
    @(negedge clock); value_in = 14'd8765; load = 1'b1;
    @(posedge clock); #1 load = 1'b0;
    repeat (6) begin @(posedge clock); #1; end
    reset_L = 1'b0;
    #1;
    checks++;
    if (bcd_out !== 16'h0000 || blank_out !== 4'b1110 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got bcd=%h blank=%b busy=%b done=%b want 0000 1110 0 0",
               bcd_out, blank_out, busy, done);
    end
    @(posedge clock);
    @(negedge clock); reset_L = 1'b1;
    saw_done = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (done || busy) saw_done = 1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_discard got stray done/busy want none");
    end
    run_conv(9, 1, 1, "after_reset9");
  endtask

  task automatic test_back_to_back();
    int d1, d2, c;
    logic [15:0] r1, r2;
    @(negedge clock); lz_blank_en = 1'b0; display_en = 1'b1;
    @(negedge clock); value_in = 14'd2468; load = 1'b1;
    @(posedge clock); #1 value_in = 14'd135;
    d1 = 0; d2 = 0; r1 = '0; r2 = '0;
    for (c = 1; c <= 40 && d2 == 0; c++) begin
      if (done) begin
        if (d1 == 0) begin d1 = c; r1 = bcd_out; end
        else begin d2 = c; r2 = bcd_out; load = 1'b0; end
      end
      if (d2 == 0) begin @(posedge clock); #1; end
    end
    load = 1'b0;
    checks++;
    if (d1 !== 16 || d2 !== 32) begin
      failures++;
      $display("FAIL b2b_timing got done at %0d,%0d want 16,32", d1, d2);
    end
    checks++;
    if (r1 !== exp_bcd(2468) || r2 !== exp_bcd(135)) begin
      failures++;
      $display("FAIL b2b_values got %h,%h want %h,%h", r1, r2, exp_bcd(2468), exp_bcd(135));
    end
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_stop got busy=%b want 0", busy);
    end
  endtask

  task automatic test_random();
    int v;
    bit lz, de;
    for (int k = 0; k < 10; k++) begin
      v  = int'($urandom_range(0, 16383));
      lz = 1'($urandom_range(0, 1));
      de = ($urandom_range(0, 3) != 0);
      if (k < 3) v = int'($urandom_range(0, 99));
      run_conv(v, lz, de, "rand");
    end
  endtask

  initial begin
    reset_L = 1'b0; load = 1'b0; value_in = '0;
    lz_blank_en = 1'b1; display_en = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock); reset_L = 1'b1;
    test_reset();
    test_basic();
    test_saturation();
    test_load_while_busy();
    test_display_toggle();
    test_reset_mid_conv();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
